// File: rtl/ula_muldiv_if.sv
// Operand, opcode, handshake and result bundle between the control/execute stage and ula_muldiv.
interface ula_muldiv_if #(
    parameter int unsigned WIDTH = 32
);
    localparam int unsigned SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] In1;
    logic [WIDTH-1:0] In2;
    logic [SHW-1:0]   shamt;
    logic [3:0]       OP;
    logic             start;
    logic [WIDTH-1:0] result;
    logic             Zero_flag;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_zero;

    // Issuing side: drives operands and start, observes results.
    modport master (
        output In1, In2, shamt, OP, start,
        input  result, Zero_flag, hi, lo, busy, done, div_zero
    );

    // ALU side: consumes operands, produces results.
    modport slave (
        input  In1, In2, shamt, OP, start,
        output result, Zero_flag, hi, lo, busy, done, div_zero
    );
endinterface

// File: rtl/ula_muldiv.sv
// Execute-stage ALU: single-cycle combinational ops plus an iterative
// radix-2 multiply/divide engine writing HI/LO with a start/busy/done handshake.
module ula_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    ula_muldiv_if.slave bus
);
    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned CW  = $clog2(WIDTH + 1);
    localparam int unsigned PW  = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             op_div;
    logic             neg_q;
    logic             neg_r;
    logic [WIDTH-1:0] opnd_b;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             busy_q;
    logic             done_q;
    logic             dz_q;

    logic [SHW-1:0]   sa;
    logic [WIDTH-1:0] alu;

    logic             is_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic             ge;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    logic [PW-1:0]    prod_fix;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] fin_hi;
    logic [WIDTH-1:0] fin_lo;

    // Single-cycle operations; shift amount is In1 low bits plus shamt, wrapping.
    always_comb begin
        sa  = bus.In1[SHW-1:0] + bus.shamt;
        alu = '0;
        case (bus.OP)
            4'b0000: alu = bus.In1 + bus.In2;
            4'b0001: alu = bus.In1 - bus.In2;
            4'b0010: alu = bus.In1 & bus.In2;
            4'b0011: alu = bus.In1 | bus.In2;
            4'b0100: alu = bus.In1 ^ bus.In2;
            4'b0101: alu = ~(bus.In1 | bus.In2);
            4'b0110: alu = WIDTH'($signed(bus.In1) < $signed(bus.In2));
            4'b0111: alu = WIDTH'(bus.In1 < bus.In2);
            4'b1000: alu = bus.In2 << sa;
            4'b1001: alu = bus.In2 >> sa;
            4'b1010: alu = $unsigned($signed(bus.In2) >>> sa);
            4'b1011: alu = {bus.In2[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            default: alu = '0;
        endcase
    end

    assign bus.result    = alu;
    assign bus.Zero_flag = (alu == '0);

    // Operand magnitudes for launch; OP[0]=0 selects the signed variants.
    always_comb begin
        is_signed = ~bus.OP[0];
        a_neg     = is_signed & bus.In1[WIDTH-1];
        b_neg     = is_signed & bus.In2[WIDTH-1];
        a_mag     = a_neg ? -bus.In1 : bus.In1;
        b_mag     = b_neg ? -bus.In2 : bus.In2;
    end

    // One radix-2 step: shift-add multiply or restoring divide on {acc_hi, acc_lo}.
    always_comb begin
        addend  = acc_lo[0] ? opnd_b : '0;
        sum     = {1'b0, acc_hi} + {1'b0, addend};
        shifted = {acc_hi, acc_lo[WIDTH-1]};
        ge      = (shifted >= {1'b0, opnd_b});
        if (op_div) begin
            step_hi = ge ? WIDTH'(shifted - {1'b0, opnd_b}) : shifted[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], ge};
        end else begin
            step_hi = sum[WIDTH:1];
            step_lo = {sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    // Sign correction applied to the last step's output as it is written to HI/LO.
    always_comb begin
        prod_fix = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
        quo_fix  = neg_q ? -step_lo : step_lo;
        rem_fix  = neg_r ? -step_hi : step_hi;
        fin_hi   = op_div ? rem_fix : prod_fix[PW-1:WIDTH];
        fin_lo   = op_div ? quo_fix : prod_fix[WIDTH-1:0];
    end

    // Engine FSM: launch in IDLE, WIDTH steps in RUN, one-cycle done in FIN.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            op_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            opnd_b <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && (bus.OP[3:2] == 2'b11)) begin
                        op_div <= bus.OP[1];
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        if (bus.OP[1] && (bus.In2 == '0)) begin
                            // Division by zero: no iteration, dividend passes to HI.
                            hi_q   <= bus.In1;
                            lo_q   <= '1;
                            done_q <= 1'b1;
                            dz_q   <= 1'b1;
                            state  <= FIN;
                        end else begin
                            opnd_b <= bus.OP[1] ? b_mag : a_mag;
                            acc_hi <= '0;
                            acc_lo <= bus.OP[1] ? a_mag : b_mag;
                            cnt    <= CW'(WIDTH);
                            busy_q <= 1'b1;
                            state  <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        hi_q   <= fin_hi;
                        lo_q   <= fin_lo;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= FIN;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;

endmodule

// File: tb/tb_ula_muldiv.sv
// Directed bench for ula_muldiv at WIDTH=32 and WIDTH=16.
module tb_ula_muldiv;
    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    ula_muldiv_if #(.WIDTH(32)) b32 ();
    ula_muldiv_if #(.WIDTH(16)) b16 ();

    ula_muldiv #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(b32));
    ula_muldiv #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .bus(b16));

    // Count one comparison and report it if it differs.
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Single-cycle op at WIDTH=32; called right after a falling edge.
    task automatic alu32(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh, input logic [31:0] exp);
        b32.OP = op; b32.In1 = a; b32.In2 = b; b32.shamt = sh;
        #1;
        check(tag, 64'(b32.result), 64'(exp));
        check({tag, ":zf"}, 64'(b32.Zero_flag), 64'(exp == 32'd0));
        @(negedge clk);
    endtask

    // Launch a mult/div at WIDTH=32 and check latency, busy span and HI/LO.
    task automatic run32(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                         input int elat, input logic edz);
        int cyc;
        int nbusy;
        logic seen;
        b32.OP = op; b32.In1 = a; b32.In2 = b; b32.start = 1'b1;
        @(negedge clk);
        b32.start = 1'b0;
        b32.In1 = $urandom; b32.In2 = $urandom;
        cyc = 1; nbusy = 0; seen = 1'b0;
        while (!seen && cyc <= 100) begin
            if (b32.done) seen = 1'b1;
            else begin
                if (b32.busy) nbusy++;
                cyc++;
                @(negedge clk);
            end
        end
        check({tag, ":done"}, 64'(seen), 64'd1);
        check({tag, ":lat"}, 64'(cyc), 64'(elat));
        check({tag, ":busycyc"}, 64'(nbusy), 64'(elat - 1));
        check({tag, ":busy_fin"}, 64'(b32.busy), 64'd0);
        check({tag, ":hi"}, 64'(b32.hi), 64'(ehi));
        check({tag, ":lo"}, 64'(b32.lo), 64'(elo));
        check({tag, ":dz"}, 64'(b32.div_zero), 64'(edz));
        @(negedge clk);
        check({tag, ":pulse"}, 64'({b32.done, b32.div_zero}), 64'd0);
    endtask

    // Same as run32 for the WIDTH=16 instance.
    task automatic run16(input string tag, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] ehi, input logic [15:0] elo,
                         input int elat, input logic edz);
        int cyc;
        int nbusy;
        logic seen;
        b16.OP = op; b16.In1 = a; b16.In2 = b; b16.start = 1'b1;
        @(negedge clk);
        b16.start = 1'b0;
        b16.In1 = 16'($urandom); b16.In2 = 16'($urandom);
        cyc = 1; nbusy = 0; seen = 1'b0;
        while (!seen && cyc <= 100) begin
            if (b16.done) seen = 1'b1;
            else begin
                if (b16.busy) nbusy++;
                cyc++;
                @(negedge clk);
            end
        end
        check({tag, ":done"}, 64'(seen), 64'd1);
        check({tag, ":lat"}, 64'(cyc), 64'(elat));
        check({tag, ":busycyc"}, 64'(nbusy), 64'(elat - 1));
        check({tag, ":hi"}, 64'(b16.hi), 64'(ehi));
        check({tag, ":lo"}, 64'(b16.lo), 64'(elo));
        check({tag, ":dz"}, 64'(b16.div_zero), 64'(edz));
        @(negedge clk);
        check({tag, ":pulse"}, 64'({b16.done, b16.div_zero}), 64'd0);
    endtask

    initial begin
        int cyc;
        int ndone;
        logic seen;

        reset = 1'b1;
        b32.In1 = '0; b32.In2 = '0; b32.shamt = '0; b32.OP = '0; b32.start = 1'b0;
        b16.In1 = '0; b16.In2 = '0; b16.shamt = '0; b16.OP = '0; b16.start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst:hi", 64'(b32.hi), 64'd0);
        check("rst:lo", 64'(b32.lo), 64'd0);
        check("rst:flags", 64'({b32.busy, b32.done, b32.div_zero}), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single-cycle operations
        alu32("add_wrap", 4'b0000, 32'hFFFF_FFFF, 32'h1,         5'd0, 32'h0);
        alu32("sub",      4'b0001, 32'd5,         32'd7,         5'd0, 32'hFFFF_FFFE);
        alu32("and",      4'b0010, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hF000_F000);
        alu32("or",       4'b0011, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hFFF0_FFF0);
        alu32("xor",      4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'h0FF0_0FF0);
        alu32("nor",      4'b0101, 32'h0,         32'h0,         5'd0, 32'hFFFF_FFFF);
        alu32("slt",      4'b0110, 32'hFFFF_FFFF, 32'h1,         5'd0, 32'h1);
        alu32("sltu",     4'b0111, 32'hFFFF_FFFF, 32'h1,         5'd0, 32'h0);
        alu32("sra",      4'b1010, 32'h0,         32'h8000_0000, 5'd4, 32'hF800_0000);
        alu32("srl",      4'b1001, 32'h0,         32'h8000_0000, 5'd4, 32'h0800_0000);
        alu32("sll_wrap", 4'b1000, 32'd20,        32'h1,         5'd20, 32'h0000_0100);
        alu32("sra_wrap0",4'b1010, 32'd31,        32'h8000_0000, 5'd1, 32'h8000_0000);
        alu32("lui",      4'b1011, 32'h0,         32'hABCD_1234, 5'd0, 32'h1234_0000);
        alu32("op_mult",  4'b1100, 32'd3,         32'd5,         5'd0, 32'h0);
        alu32("op_divu",  4'b1111, 32'd3,         32'd5,         5'd0, 32'h0);

        // Multiply/divide at WIDTH=32
        run32("mult",    4'b1100, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33, 1'b0);
        run32("multu",   4'b1101, 32'hFFFF_FFFD, 32'd7, 32'h0000_0006, 32'hFFFF_FFEB, 33, 1'b0);
        run32("div",     4'b1110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 1'b0);
        run32("divu",    4'b1111, 32'd100,       32'd7, 32'd2,         32'd14,        33, 1'b0);
        run32("div_ovf", 4'b1110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33, 1'b0);
        run32("divu_z",  4'b1111, 32'd5,         32'd0, 32'd5,         32'hFFFF_FFFF, 1,  1'b1);
        run32("div_z",   4'b1110, 32'hFFFF_FFFD, 32'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1,  1'b1);

        // Second start while running is ignored
        b32.OP = 4'b1101; b32.In1 = 32'd3; b32.In2 = 32'd5; b32.start = 1'b1;
        @(negedge clk);
        b32.start = 1'b0;
        cyc = 1; seen = 1'b0;
        while (!seen && cyc <= 100) begin
            if (b32.done) seen = 1'b1;
            else begin
                if (cyc == 5) begin
                    b32.start = 1'b1; b32.OP = 4'b1111; b32.In1 = 32'd100; b32.In2 = 32'd7;
                end else b32.start = 1'b0;
                @(negedge clk);
                cyc++;
            end
        end
        b32.start = 1'b0;
        check("restart:lat", 64'(cyc), 64'd33);
        check("restart:hi", 64'(b32.hi), 64'd0);
        check("restart:lo", 64'(b32.lo), 64'd15);
        @(negedge clk);

        // Reset in cycle 10 of a multiply aborts it
        b32.OP = 4'b1100; b32.In1 = 32'hFFFF_FFFD; b32.In2 = 32'd7; b32.start = 1'b1;
        @(negedge clk);
        b32.start = 1'b0;
        repeat (9) @(negedge clk);
        check("abort:busy_c10", 64'(b32.busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort:busy", 64'(b32.busy), 64'd0);
        check("abort:hi", 64'(b32.hi), 64'd0);
        check("abort:lo", 64'(b32.lo), 64'd0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (b32.done) ndone++;
            @(negedge clk);
        end
        check("abort:no_done", 64'(ndone), 64'd0);
        run32("after_rst", 4'b1111, 32'd100, 32'd7, 32'd2, 32'd14, 33, 1'b0);

        // Multiply/divide at WIDTH=16
        run16("m16",      4'b1100, 16'hFFFD, 16'd7,   16'hFFFF, 16'hFFEB, 17, 1'b0);
        run16("mu16",     4'b1101, 16'hFFFD, 16'd7,   16'h0006, 16'hFFEB, 17, 1'b0);
        run16("d16",      4'b1110, 16'hFFF9, 16'd2,   16'hFFFF, 16'hFFFD, 17, 1'b0);
        run16("du16",     4'b1111, 16'd100,  16'd7,   16'd2,    16'd14,   17, 1'b0);
        run16("d16_ovf",  4'b1110, 16'h8000, 16'hFFFF, 16'h0,   16'h8000, 17, 1'b0);
        run16("du16_z",   4'b1111, 16'd5,    16'd0,   16'd5,    16'hFFFF, 1,  1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Backstop so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/ula_muldiv.md
Name: ula_muldiv

Overview:
- Next-generation ALU, parametrised in data width.
- Keeps the full single-cycle combinational operation set: ADD/SUB/logic/compare/shift/LUI.
- Adds a multi-cycle iterative multiply/divide engine with HI/LO result registers and a start/busy/done handshake.
- Sits in the execute stage; the control unit stalls the pipeline while busy is high.

Parameters:
- WIDTH, 32, operand/result width; even power of two, minimum 8.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- In1  in  WIDTH  operand 1; also the dividend / multiplicand.
- In2  in  WIDTH  operand 2; also the divisor / multiplier.
- shamt  in  SHW  instruction shift amount.
- OP  in  4  operation code.
- start  in  1  launches a mult/div when OP is 1100–1111.
- result  out  WIDTH  combinational result of the single-cycle ops.
- Zero_flag  out  1  high when result equals 0.
- hi  out  WIDTH  HI register: product high half, or remainder.
- lo  out  WIDTH  LO register: product low half, or quotient.
- busy  out  1  engine running.
- done  out  1  one-cycle pulse when hi/lo are updated.
- div_zero  out  1  one-cycle pulse, coincident with done, for division by zero.

Behaviour:
- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 NOR.
  - 0110 SLT (signed), 0111 SLTU.
  - 1000 SLL, 1001 SRL, 1010 SRA.
  - 1011 LUI: {In2[WIDTH/2-1:0], WIDTH/2 zeros}.
  - 1100 MULT, 1101 MULTU, 1110 DIV, 1111 DIVU.
- Shift amount = (In1[SHW-1:0] + shamt), truncated to SHW bits (wraps modulo WIDTH). Shifted value is In2; SRA is arithmetic.
- result is purely combinational, independent of the engine state. For opcodes 1100–1111 result = 0, so Zero_flag = 1.
- ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
- Reset: state IDLE; hi = lo = 0; busy = done = div_zero = 0; internal accumulators cleared. Reset wins over start in the same cycle. Reset mid-operation aborts the operation and leaves hi/lo at 0.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - Advances when start = 1 and OP[3:2] = 11.
  - Captures operand magnitudes and the result-sign bits. Signed ops use two's-complement magnitude; the most negative value maps to 2^(WIDTH-1).
  - Loads iteration counter = WIDTH and goes to RUN.
  - DIV/DIVU with In2 = 0 goes directly to FIN instead.
  - start with any other OP is ignored.
- RUN:
  - busy = 1; one radix-2 step per cycle (shift-add multiply, restoring divide).
  - Counter decrements; goes to FIN after exactly WIDTH cycles.
- FIN (one cycle):
  - done = 1, busy = 0; hi/lo are written on the edge entering FIN and are visible in this cycle.
  - Sign fix:
    - MULT: 2·WIDTH-bit product negated if operand signs differ.
    - DIV: quotient negated if signs differ; remainder takes the sign of the dividend.
  - Returns to IDLE.
- Latency: start sampled at edge 0 → busy high for cycles 1..WIDTH → done in cycle WIDTH+1. Division by zero: done in cycle 1.
- Division by zero: hi = In1 (unchanged dividend), lo = all ones, div_zero = 1.
- DIV of most-negative value by −1: lo = most-negative value, hi = 0; no trap.
- start while busy, or in FIN, is ignored. Operands are sampled only in IDLE; later changes to In1/In2 do not affect the running operation.
- hi/lo hold their values until the next completed operation.

Test Plan:
- WIDTH=32; sweep each single-cycle op:
  - ADD 0xFFFFFFFF+1 → result 0, Zero_flag 1.
  - SLT 0xFFFFFFFF vs 1 → 1; SLTU same operands → 0.
  - SRA In2=0x80000000, In1=0, shamt=4 → 0xF8000000.
  - LUI In2=0x1234 → 0x12340000.
- Shift wrap: In1[4:0]=20, shamt=20 → shift by 8; SLL In2=1 → 0x00000100.
- MULT 0xFFFFFFFD × 7 with start pulse:
  - busy for cycles 1..32, done in cycle 33.
  - hi=0xFFFFFFFF, lo=0xFFFFFFEB.
  - MULTU with the same operands → hi=0x00000006, lo=0xFFFFFFEB.
- DIV −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 → lo=14, hi=2.
- DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU 5/0 → done and div_zero in cycle 1; hi=5, lo=0xFFFFFFFF.
- Second start mid-RUN is ignored and the first result is unchanged.
- reset at cycle 10 of a MULT → next cycle busy=0, hi=lo=0, and no done pulse.
- Repeat the MULT and DIV cases with WIDTH=16; done arrives in cycle 17.
